ff_excitation_decoder: RTL and testbench
========================================

FF_EXCITATION_DECODER -- requirements
Module: ff_excitation_decoder

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of each event counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have port: q_valid  input  1  q_in carries a new observed flip-flop state this cycle.
REQ-005 SHALL have port: q_in  input  1  observed flip-flop output sample.
REQ-006 SHALL have port: cnt_clr  input  1  synchronous clear of all event counters.
REQ-007 SHALL have port: exc_valid  output  1  excitation outputs valid for the latest transition (one-cycle pulse).
REQ-008 SHALL have port: d_out, t_out  output  1 each  D and T excitation for the transition.
REQ-009 SHALL have port: s_out, r_out, sr_dc  output  1 each  SR excitation; sr_dc flags the don't-care input (S on 1->1, R on 0->0), whose value is driven 0.
REQ-010 SHALL have port: j_out, k_out, jk_dc  output  1 each  JK excitation; jk_dc flags the don't-care input (K on 0->x, J on 1->x), whose value is driven 0.
REQ-011 SHALL have port: rise_cnt, fall_cnt, hold_cnt  output  CNT_W each  counts of 0->1, 1->0, and hold transitions.

Function
REQ-012 SHALL implement two states: EMPTY (no previous sample held) and PRIMED (previous sample prev_q held).
REQ-013 In EMPTY with q_valid=1, SHALL store q_in as prev_q, go to PRIMED, and not assert exc_valid (the first sample has no transition).
REQ-014 In PRIMED with q_valid=1, SHALL decode transition prev_q->q_in, register all excitation outputs, pulse exc_valid for exactly the next cycle, and update prev_q to q_in.
REQ-015 Latency SHALL be one cycle: outputs for the sample taken at edge N are visible after edge N and held until the next decoded transition.
REQ-016 Decode table (prev->new : D T S R sr_dc J K jk_dc) SHALL be: 0->0: 0 0 0 0 1 0 0 1; 0->1: 1 1 1 0 0 1 0 1; 1->0: 0 1 0 1 0 0 1 1; 1->1: 1 0 0 0 1 0 0 1.
REQ-017 jk_dc SHALL be 1 for every transition; sr_dc SHALL be 1 only for hold transitions.
REQ-018 q_valid=0 SHALL leave state, prev_q, excitation outputs, and counters unchanged; exc_valid SHALL be 0.
REQ-019 On each decoded transition SHALL increment exactly one counter: rise_cnt (0->1), fall_cnt (1->0), or hold_cnt (0->0 or 1->1).
REQ-020 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-021 cnt_clr=1 SHALL zero all counters on that edge; if a transition is decoded on the same edge, the clear wins (counters 0), and excitation outputs and exc_valid still update.
REQ-022 cnt_clr SHALL NOT affect FSM state or prev_q.

Reset
REQ-023 reset=1 SHALL asynchronously force state EMPTY, prev_q=0, exc_valid=0, all excitation outputs and dc flags 0, and all counters 0.
REQ-024 Reset asserted mid-stream SHALL discard prev_q; after release, the first valid sample SHALL re-prime without asserting exc_valid.
REQ-025 Reset SHALL take effect without a clock edge and SHALL be held until deasserted, with no glitch on exc_valid.

Verification
REQ-026 Sample sequence 0,1,1,0,0 (q_valid each cycle) -> no pulse on the first sample, then four exc_valid pulses matching the REQ-016 rows 0->1, 1->1, 1->0, 0->0; rise=1, fall=1, hold=2.
REQ-027 Samples 1,0 separated by three q_valid=0 cycles -> a single exc_valid one cycle after the second sample, with d=0, t=1, r=1, k=1; outputs hold during the idle gaps.
REQ-028 CNT_W=2, five consecutive 0->1/1->0 pairs -> rise_cnt and fall_cnt stop at 3.
REQ-029 cnt_clr on the same edge as a 0->1 decode -> rise_cnt=0, exc_valid=1, j_out=1.
REQ-030 Reset asserted between clock edges while PRIMED with prev_q=1 -> outputs zero immediately; the next sample 0 gives no exc_valid; the following sample 0 gives a 0->0 decode.

Source files
------------

// File: rtl/ff_excitation_decoder_if.sv
// Sample-in / excitation-out bundle for the flip-flop excitation decoder.
// master drives samples and counter clear; slave returns decoded excitation and counts.
interface ff_excitation_decoder_if #(
    parameter int CNT_W = 8
);
    logic             q_valid;
    logic             q_in;
    logic             cnt_clr;
    logic             exc_valid;
    logic             d_out;
    logic             t_out;
    logic             s_out;
    logic             r_out;
    logic             sr_dc;
    logic             j_out;
    logic             k_out;
    logic             jk_dc;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic [CNT_W-1:0] hold_cnt;

    modport master (
        output q_valid, q_in, cnt_clr,
        input  exc_valid, d_out, t_out, s_out, r_out, sr_dc,
        input  j_out, k_out, jk_dc, rise_cnt, fall_cnt, hold_cnt
    );

    modport slave (
        input  q_valid, q_in, cnt_clr,
        output exc_valid, d_out, t_out, s_out, r_out, sr_dc,
        output j_out, k_out, jk_dc, rise_cnt, fall_cnt, hold_cnt
    );
endinterface

// File: rtl/ff_excitation_decoder.sv
// Decodes D/T/SR/JK excitation for each observed flip-flop transition and counts rise/fall/hold events.
// Latency: one cycle from the accepted sample to exc_valid and registered outputs.
// Backpressure: none; every q_valid sample is accepted, outputs hold until the next decode.
module ff_excitation_decoder #(
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    ff_excitation_decoder_if.slave  bus
);
    typedef enum logic {EMPTY, PRIMED} state_t;

    state_t           state;
    logic             prev_q;
    logic             exc_valid;
    logic             d_out, t_out, s_out, r_out, sr_dc;
    logic             j_out, k_out, jk_dc;
    logic [CNT_W-1:0] rise_cnt, fall_cnt, hold_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            prev_q    <= 1'b0;
            exc_valid <= 1'b0;
            d_out     <= 1'b0;
            t_out     <= 1'b0;
            s_out     <= 1'b0;
            r_out     <= 1'b0;
            sr_dc     <= 1'b0;
            j_out     <= 1'b0;
            k_out     <= 1'b0;
            jk_dc     <= 1'b0;
            rise_cnt  <= '0;
            fall_cnt  <= '0;
            hold_cnt  <= '0;
        end else begin
            exc_valid <= 1'b0;
            if (bus.cnt_clr) begin
                rise_cnt <= '0;
                fall_cnt <= '0;
                hold_cnt <= '0;
            end
            if (bus.q_valid) begin
                prev_q <= bus.q_in;
                if (state == EMPTY) begin
                    state <= PRIMED;
                end else begin
                    exc_valid <= 1'b1;
                    d_out     <= bus.q_in;
                    t_out     <= prev_q ^ bus.q_in;
                    s_out     <= ~prev_q & bus.q_in;
                    r_out     <= prev_q & ~bus.q_in;
                    sr_dc     <= ~(prev_q ^ bus.q_in);
                    j_out     <= ~prev_q & bus.q_in;
                    k_out     <= prev_q & ~bus.q_in;
                    // Every JK transition leaves one input free, so the flag is always set.
                    jk_dc     <= 1'b1;
                    if (!bus.cnt_clr) begin
                        if (!prev_q && bus.q_in)
                            rise_cnt <= sat_inc(rise_cnt);
                        else if (prev_q && !bus.q_in)
                            fall_cnt <= sat_inc(fall_cnt);
                        else
                            hold_cnt <= sat_inc(hold_cnt);
                    end
                end
            end
        end
    end

    assign bus.exc_valid = exc_valid;
    assign bus.d_out     = d_out;
    assign bus.t_out     = t_out;
    assign bus.s_out     = s_out;
    assign bus.r_out     = r_out;
    assign bus.sr_dc     = sr_dc;
    assign bus.j_out     = j_out;
    assign bus.k_out     = k_out;
    assign bus.jk_dc     = jk_dc;
    assign bus.rise_cnt  = rise_cnt;
    assign bus.fall_cnt  = fall_cnt;
    assign bus.hold_cnt  = hold_cnt;
endmodule

// File: tb/tb_ff_excitation_decoder.sv
// Directed bench for ff_excitation_decoder: 8-bit and 2-bit counter instances driven in lockstep.
module tb_ff_excitation_decoder;
    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    ff_excitation_decoder_if #(.CNT_W(8)) bus8 ();
    ff_excitation_decoder_if #(.CNT_W(2)) bus2 ();

    ff_excitation_decoder #(.CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    ff_excitation_decoder #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed excitation order: {d, t, s, r, sr_dc, j, k, jk_dc}
    localparam logic [7:0] EXC_00 = 8'h09;
    localparam logic [7:0] EXC_01 = 8'hE5;
    localparam logic [7:0] EXC_10 = 8'h53;
    localparam logic [7:0] EXC_11 = 8'h89;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic chk_exc(input string tag, input logic [7:0] exp);
        chk(tag, {24'h0, bus8.d_out, bus8.t_out, bus8.s_out, bus8.r_out,
                  bus8.sr_dc, bus8.j_out, bus8.k_out, bus8.jk_dc}, {24'h0, exp});
    endtask

    task automatic step(input logic v, input logic q, input logic clr);
        @(negedge clk);
        bus8.q_valid = v;  bus8.q_in = q;  bus8.cnt_clr = clr;
        bus2.q_valid = v;  bus2.q_in = q;  bus2.cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus8.q_valid = 1'b0;  bus8.cnt_clr = 1'b0;
        bus2.q_valid = 1'b0;  bus2.cnt_clr = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        bus8.q_valid = 1'b0;  bus8.q_in = 1'b0;  bus8.cnt_clr = 1'b0;
        bus2.q_valid = 1'b0;  bus2.q_in = 1'b0;  bus2.cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_valid", {31'h0, bus8.exc_valid}, 32'h0);
        chk_exc("rst_exc", 8'h00);
        chk("rst_rise", {24'h0, bus8.rise_cnt}, 32'h0);
        chk("rst_hold", {24'h0, bus8.hold_cnt}, 32'h0);

        // Sequence 0,1,1,0,0
        step(1'b1, 1'b0, 1'b0);
        chk("seq_first_nopulse", {31'h0, bus8.exc_valid}, 32'h0);
        step(1'b1, 1'b1, 1'b0);
        chk("seq01_valid", {31'h0, bus8.exc_valid}, 32'h1);
        chk_exc("seq01_exc", EXC_01);
        step(1'b1, 1'b1, 1'b0);
        chk("seq11_valid", {31'h0, bus8.exc_valid}, 32'h1);
        chk_exc("seq11_exc", EXC_11);
        step(1'b1, 1'b0, 1'b0);
        chk_exc("seq10_exc", EXC_10);
        step(1'b1, 1'b0, 1'b0);
        chk("seq00_valid", {31'h0, bus8.exc_valid}, 32'h1);
        chk_exc("seq00_exc", EXC_00);
        chk("seq_rise", {24'h0, bus8.rise_cnt}, 32'd1);
        chk("seq_fall", {24'h0, bus8.fall_cnt}, 32'd1);
        chk("seq_hold", {24'h0, bus8.hold_cnt}, 32'd2);

        // Samples 1 and 0 separated by idle cycles
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        chk("gap_first_nopulse", {31'h0, bus8.exc_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("gap_idle_valid", {31'h0, bus8.exc_valid}, 32'h0);
            chk_exc("gap_idle_exc", 8'h00);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("gap_valid", {31'h0, bus8.exc_valid}, 32'h1);
        chk_exc("gap_exc", EXC_10);
        step(1'b0, 1'b1, 1'b0);
        chk("gap_after_valid", {31'h0, bus8.exc_valid}, 32'h0);
        chk_exc("gap_after_hold", EXC_10);
        chk("gap_fall", {24'h0, bus8.fall_cnt}, 32'd1);

        // Clear on the same edge as a 0->1 decode (prev_q is 0 here)
        step(1'b1, 1'b1, 1'b1);
        chk("clr_rise", {24'h0, bus8.rise_cnt}, 32'h0);
        chk("clr_fall", {24'h0, bus8.fall_cnt}, 32'h0);
        chk("clr_valid", {31'h0, bus8.exc_valid}, 32'h1);
        chk("clr_j", {31'h0, bus8.j_out}, 32'h1);
        step(1'b1, 1'b0, 1'b0);
        chk_exc("clr_prev_kept", EXC_10);
        chk("clr_fall_after", {24'h0, bus8.fall_cnt}, 32'd1);

        // Asynchronous reset between edges while primed with prev_q=1
        step(1'b1, 1'b1, 1'b0);
        chk("ar_pre_valid", {31'h0, bus8.exc_valid}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid_now", {31'h0, bus8.exc_valid}, 32'h0);
        chk_exc("ar_exc_now", 8'h00);
        chk("ar_rise_now", {24'h0, bus8.rise_cnt}, 32'h0);
        @(negedge clk);
        bus8.q_valid = 1'b0;  bus2.q_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_held_valid", {31'h0, bus8.exc_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk("ar_reprime_nopulse", {31'h0, bus8.exc_valid}, 32'h0);
        step(1'b1, 1'b0, 1'b0);
        chk("ar_00_valid", {31'h0, bus8.exc_valid}, 32'h1);
        chk_exc("ar_00_exc", EXC_00);
        chk("ar_00_hold", {24'h0, bus8.hold_cnt}, 32'd1);

        // Saturation: five 0->1 / 1->0 pairs
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
        chk("sat2_rise", {30'h0, bus2.rise_cnt}, 32'd3);
        chk("sat2_fall", {30'h0, bus2.fall_cnt}, 32'd3);
        chk("sat8_rise", {24'h0, bus8.rise_cnt}, 32'd5);
        chk("sat8_fall", {24'h0, bus8.fall_cnt}, 32'd5);
        chk("sat2_hold", {30'h0, bus2.hold_cnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
